led_blink_scheduler: RTL and testbench
======================================

# led_blink_scheduler

Multi-channel LED blink controller that shares one free-running tick prescaler across `NUM_LEDS` LED channels. Each channel is programmed through a valid/ready configuration port with a mode (off, on, continuous blink or counted burst) and a half-period. Channels are sequenced against the common tick, and each burst reports completion. It sits between the board-level control logic and the LED pins, and replaces one fixed-rate toggle counter per LED.

## Interface
Parameters:
- `NUM_LEDS`, 4: number of LED channels (2..16).
- `TICK_DIV`, 50: clock cycles per tick; prescaler counts 0..TICK_DIV-1.
- `CNT_W`, 8: width of the half-period, phase and burst counters.

Ports:
- `clock`  in  1  single clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `io_cfg_valid`  in  1  configuration request.
- `io_cfg_ready`  out  1  configuration can be accepted this cycle.
- `io_cfg_chan`  in  clog2(NUM_LEDS)  target channel.
- `io_cfg_mode`  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- `io_cfg_half`  in  CNT_W  half-period in ticks; 0 is treated as 1.
- `io_cfg_count`  in  CNT_W  BURST pulse count.
- `io_leds`  out  NUM_LEDS  LED drive; bit i belongs to channel i.
- `io_busy`  out  NUM_LEDS  channel i is running a BURST.
- `io_done`  out  NUM_LEDS  one-cycle pulse when the burst on channel i completes.

## Operation
- **Prescaler:** free-running; `tick` = (value == TICK_DIV-1); wraps to 0 after TICK_DIV-1. The prescaler is never reset by configuration.
- **Config acceptance:** a transfer occurs when valid && ready. The fields are latched into a one-entry holding register.
  - Ready is low while the holding register is full.
  - The holding register is applied to its channel on the next edge, then empties.
- **Apply per mode:**
  - OFF: led=0, busy=0.
  - ON: led=1, busy=0.
  - BLINK: led=1, phase=0, busy=0.
  - BURST, count != 0: led=1, phase=0, remaining=count, busy=1.
  - BURST, count == 0: led=0, busy=0, and done pulses the cycle after apply.
- **Reconfiguration:** applying any config to a running channel aborts the current activity immediately, with no done pulse.
- **Tick processing (BLINK/BURST channels):**
  - If phase == max(half,1)-1: phase=0 and led toggles.
  - Otherwise phase increments.
  - OFF and ON channels ignore ticks.
- **BURST countdown:** each 1->0 toggle decrements remaining. When remaining reaches 0, on the same edge: mode=OFF, busy=0, led=0, done=1 for exactly one cycle.
- **Collision:** if a config is applied on the same edge as a tick, apply wins for the target channel and that channel skips the tick. All other channels process the tick normally.
- **Out-of-range channel:** `io_cfg_chan` >= NUM_LEDS is accepted and dropped; no channel changes.
- **Widths:** phase and remaining are CNT_W bits. Compares are unsigned and there is no overflow path; phase never exceeds half-1.

## Timing
- **Reset (asynchronous, `reset` low):**
  - Prescaler=0, all channels OFF, io_leds=0, io_busy=0, io_done=0, holding register empty, io_cfg_ready=0.
  - io_cfg_ready=1 in the first cycle after `reset` is released.
- **Config latency:**
  - Accepted at edge E: holding register full and ready=0 during cycle E..E+1.
  - Applied at edge E+1: io_leds/io_busy reflect the new mode from E+1.
  - Ready=1 again after E+1.
  - Maximum throughput is one config per 2 cycles.
- **BLINK first toggle:** occurs on the max(half,1)-th tick after apply. That is 1..TICK_DIV cycles for half=1. Steady-state high and low times are exactly half*TICK_DIV cycles each.
- **BURST total duration:** count*2*half ticks from the first tick-aligned phase. `io_done` rises on the edge at which led falls for the last time.
- **Reset mid-operation:** all channel state is lost. No done pulse is generated, and leds go low asynchronously.
- All outputs are registered; there are no combinational paths from inputs to outputs except none. `io_cfg_ready` depends only on holding-register state.

## Test plan
- Reset: hold `reset` low 5 cycles with valid=1 -> io_leds=0, io_busy=0, io_done=0, io_cfg_ready=0. After release, ready=1 on the next cycle.
- BLINK ch0, half=1, TICK_DIV=50 -> after the first toggle, led0 alternates exactly 50 cycles high / 50 cycles low; other LEDs stay 0.
- BURST ch2, half=2, count=3 -> three pulses of 100 high / 100 low. io_done[2] is high for exactly one cycle, on the edge of the third fall, and io_busy[2] drops on the same edge.
- Back-to-back configs (valid held high, ch1 ON then ch3 ON) -> ready pattern 1,0,1. Both LEDs are on by 4 cycles after the first accept.
- Config applied on a tick edge to ch0 (BLINK, half=1) while ch1 blinks -> ch0 phase restarts with led0=1; ch1 toggles on schedule.
- Edge cases:
  - half=0 behaves as half=1.
  - BURST count=0 -> led stays 0 and a single done pulse follows apply.
  - Reset asserted mid-burst -> led and busy drop immediately, with no done pulse.

Source files
------------

// File: rtl/led_blink_scheduler.sv
// rtl/led_blink_scheduler.sv - multi-channel LED blink/burst scheduler on a shared tick prescaler
module led_blink_scheduler #(
  parameter int NUM_LEDS = 4,
  parameter int TICK_DIV = 50,
  parameter int CNT_W    = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        io_cfg_valid,
  output logic                        io_cfg_ready,
  input  logic [$clog2(NUM_LEDS)-1:0] io_cfg_chan,
  input  logic [1:0]                  io_cfg_mode,
  input  logic [CNT_W-1:0]            io_cfg_half,
  input  logic [CNT_W-1:0]            io_cfg_count,
  output logic [NUM_LEDS-1:0]         io_leds,
  output logic [NUM_LEDS-1:0]         io_busy,
  output logic [NUM_LEDS-1:0]         io_done
);

  localparam int CH_W = $clog2(NUM_LEDS);
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_t;

  logic [PW-1:0]    presc_q;
  logic             tick;
  logic             accept;
  logic             hold_full_q;
  logic [CH_W-1:0]  hold_chan_q;
  mode_t            hold_mode_q;
  logic [CNT_W-1:0] hold_half_q;
  logic [CNT_W-1:0] hold_count_q;

  mode_t            mode_q  [NUM_LEDS];
  mode_t            mode_n  [NUM_LEDS];
  logic [CNT_W-1:0] phase_q [NUM_LEDS];
  logic [CNT_W-1:0] phase_n [NUM_LEDS];
  logic [CNT_W-1:0] half_q  [NUM_LEDS];
  logic [CNT_W-1:0] half_n  [NUM_LEDS];
  logic [CNT_W-1:0] rem_q   [NUM_LEDS];
  logic [CNT_W-1:0] rem_n   [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_q, led_n, busy_q, busy_n, done_q, done_n, zpend_q, zpend_n;

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign accept  = io_cfg_valid && io_cfg_ready;
  assign io_leds = led_q;
  assign io_busy = busy_q;
  assign io_done = done_q;

  // The holding register always drains on the edge after an accept, so ready mirrors "not accepting".
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      hold_full_q  <= 1'b0;
      io_cfg_ready <= 1'b0;
      hold_chan_q  <= '0;
      hold_mode_q  <= MODE_OFF;
      hold_half_q  <= CNT_W'(1);
      hold_count_q <= '0;
    end else begin
      presc_q      <= tick ? '0 : presc_q + 1'b1;
      hold_full_q  <= accept;
      io_cfg_ready <= !accept;
      if (accept) begin
        hold_chan_q  <= io_cfg_chan;
        hold_mode_q  <= mode_t'(io_cfg_mode);
        hold_half_q  <= (io_cfg_half == '0) ? CNT_W'(1) : io_cfg_half;
        hold_count_q <= io_cfg_count;
      end
    end
  end

  // Per-channel next state; an apply to a channel takes priority over a coincident tick.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      mode_n[i]  = mode_q[i];
      phase_n[i] = phase_q[i];
      half_n[i]  = half_q[i];
      rem_n[i]   = rem_q[i];
      led_n[i]   = led_q[i];
      busy_n[i]  = busy_q[i];
      done_n[i]  = zpend_q[i];
      zpend_n[i] = 1'b0;
      if (hold_full_q && (hold_chan_q == CH_W'(i))) begin
        mode_n[i]  = hold_mode_q;
        phase_n[i] = '0;
        half_n[i]  = hold_half_q;
        rem_n[i]   = hold_count_q;
        done_n[i]  = 1'b0;
        case (hold_mode_q)
          MODE_OFF: begin
            led_n[i]  = 1'b0;
            busy_n[i] = 1'b0;
          end
          MODE_ON, MODE_BLINK: begin
            led_n[i]  = 1'b1;
            busy_n[i] = 1'b0;
          end
          default: begin
            if (hold_count_q != '0) begin
              led_n[i]  = 1'b1;
              busy_n[i] = 1'b1;
            end else begin
              mode_n[i]  = MODE_OFF;
              led_n[i]   = 1'b0;
              busy_n[i]  = 1'b0;
              zpend_n[i] = 1'b1;
            end
          end
        endcase
      end else if (tick && (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_BURST)) begin
        if (phase_q[i] == half_q[i] - 1'b1) begin
          phase_n[i] = '0;
          led_n[i]   = !led_q[i];
          if (mode_q[i] == MODE_BURST && led_q[i]) begin
            rem_n[i] = rem_q[i] - 1'b1;
            if (rem_q[i] == CNT_W'(1)) begin
              mode_n[i] = MODE_OFF;
              busy_n[i] = 1'b0;
              led_n[i]  = 1'b0;
              done_n[i] = 1'b1;
            end
          end
        end else begin
          phase_n[i] = phase_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i]  <= MODE_OFF;
        phase_q[i] <= '0;
        half_q[i]  <= CNT_W'(1);
        rem_q[i]   <= '0;
      end
      led_q   <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      zpend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i]  <= mode_n[i];
        phase_q[i] <= phase_n[i];
        half_q[i]  <= half_n[i];
        rem_q[i]   <= rem_n[i];
      end
      led_q   <= led_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      zpend_q <= zpend_n;
    end
  end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// tb/tb_led_blink_scheduler.sv - directed, table-driven bench for led_blink_scheduler
module tb_led_blink_scheduler;

  typedef struct {
    logic       valid;
    logic [1:0] chan;
    logic [1:0] mode;
    logic [7:0] half;
    logic [7:0] count;
    logic       exp_ready;
    logic [3:0] exp_leds;
    logic [3:0] exp_busy;
    logic [3:0] exp_done;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_chan = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_half = '0;
  logic [7:0] cfg_count = '0;
  logic [3:0] leds, busy, done;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  vec_t vecs[17];

  always #5 clock = ~clock;

  led_blink_scheduler #(.NUM_LEDS(4), .TICK_DIV(50), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_cfg_valid(cfg_valid),
    .io_cfg_ready(cfg_ready),
    .io_cfg_chan (cfg_chan),
    .io_cfg_mode (cfg_mode),
    .io_cfg_half (cfg_half),
    .io_cfg_count(cfg_count),
    .io_leds     (leds),
    .io_busy     (busy),
    .io_done     (done)
  );

  task automatic cyc();
    @(posedge clock);
    edge_n++;
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [1:0] m, input logic [7:0] h, input logic [7:0] n);
    cfg_valid = 1'b1;
    cfg_chan  = c;
    cfg_mode  = m;
    cfg_half  = h;
    cfg_count = n;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       l2;
    logic [3:0] exp_l;

    // {valid, chan, mode, half, count, ready, leds, busy, done} after the edge
    vecs[0]  = '{1'b1, 2'd1, 2'd1, 8'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b1, 2'd3, 2'd1, 8'd0, 8'd0, 1'b1, 4'b0010, 4'b0000, 4'b0000};
    vecs[2]  = '{1'b1, 2'd3, 2'd1, 8'd0, 8'd0, 1'b0, 4'b0010, 4'b0000, 4'b0000};
    vecs[3]  = '{1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 1'b1, 4'b1010, 4'b0000, 4'b0000};
    vecs[4]  = '{1'b1, 2'd1, 2'd0, 8'd0, 8'd0, 1'b0, 4'b1010, 4'b0000, 4'b0000};
    vecs[5]  = '{1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 1'b1, 4'b1000, 4'b0000, 4'b0000};
    vecs[6]  = '{1'b1, 2'd3, 2'd3, 8'd1, 8'd0, 1'b0, 4'b1000, 4'b0000, 4'b0000};
    vecs[7]  = '{1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    vecs[8]  = '{1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 1'b1, 4'b0000, 4'b0000, 4'b1000};
    vecs[9]  = '{1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    vecs[10] = '{1'b1, 2'd2, 2'd1, 8'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    vecs[11] = '{1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 1'b1, 4'b0100, 4'b0000, 4'b0000};
    vecs[12] = '{1'b1, 2'd2, 2'd3, 8'd5, 8'd1, 1'b0, 4'b0100, 4'b0000, 4'b0000};
    vecs[13] = '{1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 1'b1, 4'b0100, 4'b0100, 4'b0000};
    vecs[14] = '{1'b1, 2'd2, 2'd0, 8'd0, 8'd0, 1'b0, 4'b0100, 4'b0100, 4'b0000};
    vecs[15] = '{1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    vecs[16] = '{1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 1'b1, 4'b0000, 4'b0000, 4'b0000};

    cfg_valid = 1'b1;
    repeat (5) begin
      @(posedge clock);
      @(negedge clock);
    end
    chk("rst_leds", leds, 4'b0000);
    chk("rst_busy", busy, 4'b0000);
    chk("rst_done", done, 4'b0000);
    chk("rst_ready", cfg_ready, 1'b0);

    reset = 1'b1;
    cfg_valid = 1'b0;
    edge_n = 0;
    chk("rel_ready_before_edge", cfg_ready, 1'b0);
    cyc();
    chk("rel_ready_first_cycle", cfg_ready, 1'b1);

    for (int i = 0; i < 17; i++) begin
      cfg_valid = vecs[i].valid;
      cfg_chan  = vecs[i].chan;
      cfg_mode  = vecs[i].mode;
      cfg_half  = vecs[i].half;
      cfg_count = vecs[i].count;
      cyc();
      chk($sformatf("vec%0d_ready", i), cfg_ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_leds", i), leds, vecs[i].exp_leds);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
    end

    // ch0 BLINK with half=0 (acts as 1), then ch1 BLINK half=1; ticks land on edges 50,100,...
    send(2'd0, 2'd2, 8'd0, 8'd0);
    cyc();
    chk("blink0_apply", leds, 4'b0001);
    send(2'd1, 2'd2, 8'd1, 8'd0);
    cyc();
    chk("blink1_apply", leds, 4'b0011);
    run_to(49);
    chk("blink_hi_end", leds, 4'b0011);
    run_to(50);
    chk("blink_fall", leds, 4'b0000);
    run_to(99);
    chk("blink_lo_end", leds, 4'b0000);
    run_to(100);
    chk("blink_rise", leds, 4'b0011);
    run_to(148);
    send(2'd0, 2'd2, 8'd1, 8'd0);
    chk("blink_hi_149", leds, 4'b0011);
    cyc();
    chk("collide_tick", leds, 4'b0001);
    run_to(199);
    chk("collide_hold", leds, 4'b0001);
    run_to(200);
    chk("collide_next_tick", leds, 4'b0010);

    send(2'd0, 2'd0, 8'd0, 8'd0);
    cyc();
    send(2'd1, 2'd0, 8'd0, 8'd0);
    cyc();
    chk("all_off", leds, 4'b0000);

    // ch2 BURST half=2 count=3: falls at 300/500/700, rises at 400/600, done at 700
    send(2'd2, 2'd3, 8'd2, 8'd3);
    cyc();
    while (edge_n <= 710) begin
      l2 = (edge_n < 300) || (edge_n >= 400 && edge_n < 500) || (edge_n >= 600 && edge_n < 700);
      exp_l = {1'b0, l2, 2'b00};
      chk("burst_leds", leds, exp_l);
      chk("burst_busy", busy, (edge_n < 700) ? 4'b0100 : 4'b0000);
      chk("burst_done", done, (edge_n == 700) ? 4'b0100 : 4'b0000);
      cyc();
    end

    send(2'd2, 2'd3, 8'd2, 8'd3);
    cyc();
    chk("burst2_leds", leds, 4'b0100);
    chk("burst2_busy", busy, 4'b0100);
    run_to(720);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_leds", leds, 4'b0000);
    chk("midrst_busy", busy, 4'b0000);
    chk("midrst_done", done, 4'b0000);
    chk("midrst_ready", cfg_ready, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    edge_n = 0;
    repeat (3) begin
      cyc();
      chk("postrst_leds", leds, 4'b0000);
      chk("postrst_busy", busy, 4'b0000);
      chk("postrst_done", done, 4'b0000);
      chk("postrst_ready", cfg_ready, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
